// File: rtl/button_debounce_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : button_debounce_pkg                                          |
// | Description : Shared definitions for debounced-input blocks: FSM state     |
// |               encodings, default timing constants and a level helper.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package button_debounce_pkg;

  // Default qualification window: 1 ms at 50 MHz.
  localparam int DEF_STABLE_COUNT = 50000;
  localparam int DEF_CNT_WIDTH    = 16;

  // Bit 1 of the encoding is the debounced level carried by each state.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } db_state_e;

  // Debounced level implied by a state (high in IDLE_HIGH and WAIT_LOW).
  function automatic logic level_of(input db_state_e s);
    return s[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +----------------------------------------------------------------------------+
// | Module      : sync_2ff                                                     |
// | Description : Two-flop synchronizer for a single asynchronous input.       |
// |               Asynchronous active-low reset clears both stages to 0.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Next values of the two synchronizer stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer flops; only the second stage is exposed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// +----------------------------------------------------------------------------+
// | Module      : button_debounce                                              |
// | Description : Synchronizes a raw button/switch level and filters bounce    |
// |               with a stability counter and a 4-state FSM. Produces a       |
// |               registered debounced level plus one-cycle rise/fall pulses.  |
// |               Macro DEBOUNCE_FALL_PULSE_EN builds the btn_fall register;   |
// |               without it btn_fall is tied to 0.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  // Last count value of a WAIT state before the new level is accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 btn_sync;
  db_state_e            state_d, state_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 level_d, level_q;
  logic                 rise_d, rise_q;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // Next-state and stability-counter logic; the counter clears on every
  // state change and only advances while waiting for a new level to hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LOW: begin
        if (btn_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_sync) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!btn_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_sync) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values: level follows the next state, rise marks acceptance.
  always_comb begin
    level_d = level_of(state_d);
    rise_d  = (state_q == WAIT_HIGH) && (state_d == IDLE_HIGH);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_d, fall_q;

  // Fall pulse marks acceptance of a low level after a qualified wait.
  always_comb begin
    fall_d = (state_q == WAIT_LOW) && (state_d == IDLE_LOW);
  end

  // Fall pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign btn_fall = fall_q;
`else
  assign btn_fall = 1'b0;
`endif

endmodule

`default_nettype wire
